// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between ifetch (0), data (1) and loader (2).
// Fixed priority 2 > 1 > 0 by default; define MEM_ARB_RR_EN for round-robin arbitration.
module mem_port_arbiter #(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int LAT = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [2:0]      req,
  input  logic [2:0]      we,
  input  logic [3*AW-1:0] addr,
  input  logic [3*DW-1:0] wdata,
  output logic [2:0]      done,
  output logic [DW-1:0]   rdata,
  output logic [1:0]      gnt_id,
  output logic            busy,
  output logic            mem_en,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata
);

  localparam int CW = $clog2(LAT + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    mask_q, mask_d;
  logic [2:0]    done_d;
  logic [DW-1:0] rdata_d;
  logic [1:0]    gnt_d;
  logic          busy_d, mem_en_d, mem_we_d;
  logic [AW-1:0] mem_addr_d;
  logic [DW-1:0] mem_wdata_d;
  logic [2:0]    elig;
  logic [1:0]    win;

  // The requester that just finished is hidden for exactly one IDLE cycle.
  assign elig = req & ~mask_q;

`ifdef MEM_ARB_RR_EN
  logic [1:0] rr_q, rr_d;
  logic [1:0] cand;
  logic       found;

  function automatic logic [1:0] inc3(input logic [1:0] x);
    return (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  always_comb begin
    win   = 2'd0;
    found = 1'b0;
    cand  = rr_q;
    for (int i = 0; i < 3; i++) begin
      if (!found && elig[cand]) begin
        win   = cand;
        found = 1'b1;
      end
      cand = inc3(cand);
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (state_q == DONE) rr_d = inc3(gnt_id);
  end

  always_ff @(posedge clk) begin
    if (reset) rr_q <= 2'd0;
    else       rr_q <= rr_d;
  end
`else
  always_comb begin
    if (elig[2])      win = 2'd2;
    else if (elig[1]) win = 2'd1;
    else              win = 2'd0;
  end
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mask_d      = mask_q;
    done_d      = 3'b000;
    rdata_d     = rdata;
    gnt_d       = gnt_id;
    busy_d      = busy;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    case (state_q)
      IDLE: begin
        mask_d = 3'b000;
        if (|elig) begin
          state_d     = BUSY;
          cnt_d       = '0;
          gnt_d       = win;
          busy_d      = 1'b1;
          mem_en_d    = 1'b1;
          mem_we_d    = we[win];
          mem_addr_d  = addr[int'(win)*AW +: AW];
          mem_wdata_d = wdata[int'(win)*DW +: DW];
        end
      end
      BUSY: begin
        cnt_d = cnt_q + CW'(1);
        // cnt reaches LAT in the cycle mem_rdata becomes valid.
        if (cnt_q == CW'(LAT)) begin
          rdata_d = mem_rdata;
          done_d  = 3'b001 << gnt_id;
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        mask_d  = 3'b001 << gnt_id;
        gnt_d   = 2'd3;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 2'd3;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      mask_q    <= 3'b000;
      done      <= 3'b000;
      rdata     <= '0;
      gnt_id    <= 2'd3;
      busy      <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mask_q    <= mask_d;
      done      <= done_d;
      rdata     <= rdata_d;
      gnt_id    <= gnt_d;
      busy      <= busy_d;
      mem_en    <= mem_en_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed vector table, corner-case sequences and
// randomized traffic checked against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LAT = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [2:0]      req, we;
  logic [3*AW-1:0] addr;
  logic [3*DW-1:0] wdata;
  logic [2:0]      done;
  logic [DW-1:0]   rdata;
  logic [1:0]      gnt_id;
  logic            busy, mem_en, mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata, mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  mem_port_arbiter #(.AW(AW), .DW(DW), .LAT(LAT)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .done(done), .rdata(rdata), .gnt_id(gnt_id), .busy(busy), .mem_en(mem_en),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory macro model: write commits on the mem_en edge, read data valid LAT cycles later.
  logic [DW-1:0] mem_arr [256];
  logic [DW-1:0] rd_pipe [LAT];
  bit            mem_ready = 1'b0;
  logic [DW-1:0] ref_mem [256];

  assign mem_rdata = rd_pipe[LAT-1];

  function automatic logic [DW-1:0] initWord(input int i);
    if (i == 16) return 32'hDEADBEEF;
    if (i == 32) return 32'hCAFEF00D;
    return 32'h5A5A0000 + 32'(i) * 32'd7919;
  endfunction

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem_arr[i] = initWord(i);
      mem_ready <= 1'b1;
    end
    rd_pipe[0] <= mem_en ? mem_arr[mem_addr[9:2]] : '0;
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    if (mem_en && mem_we) mem_arr[mem_addr[9:2]] = mem_wdata;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish (got timeout, expected finish)");
    $fatal(1);
  end

  typedef struct {
    logic [2:0]    req;
    logic [2:0]    we;
    logic [2:0]    done;
    logic [1:0]    gnt;
    logic          busy;
    logic          en;
    logic          mwe;
    logic [AW-1:0] maddr;
    bit            chk_rd;
    logic [DW-1:0] rd;
  } vec_t;

  function automatic vec_t mk(input logic [2:0] rq, input logic [2:0] d, input logic [1:0] g,
                              input logic b, input logic e, input logic [AW-1:0] ma,
                              input bit cr, input logic [DW-1:0] rd);
    vec_t v;
    v.req = rq; v.we = 3'b000; v.done = d; v.gnt = g; v.busy = b; v.en = e;
    v.mwe = 1'b0; v.maddr = ma; v.chk_rd = cr; v.rd = rd;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] r, input logic [2:0] w);
    req = r;
    we  = w;
  endtask

  task automatic setPort(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    addr[i*AW +: AW]  = a;
    wdata[i*DW +: DW] = d;
  endtask

  task automatic doReset();
    reset = 1'b1;
    applyStimulus(3'b000, 3'b000);
    repeat (2) @(negedge clk);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_rdata", rdata, 0);
    checkOutput("rst_gnt", gnt_id, 3);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_mem_en", mem_en, 0);
    checkOutput("rst_mem_we", mem_we, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_mem_wdata", mem_wdata, 0);
    reset = 1'b0;
  endtask

  task automatic waitDone(input int idx, input int budget, input string name, output int k);
    k = 0;
    while (k < budget && done === 3'b000) begin
      @(negedge clk);
      k++;
    end
    checkOutput(name, done, 3'b001 << idx);
  endtask

  task automatic runTable();
    vec_t tbl[$];
    tbl.push_back(mk(3'b001, 3'b000, 2'd0, 1, 1, 32'h40, 0, 0));
    tbl.push_back(mk(3'b001, 3'b000, 2'd0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(3'b001, 3'b000, 2'd0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(3'b001, 3'b001, 2'd0, 1, 0, 0, 1, 32'hDEADBEEF));
    tbl.push_back(mk(3'b000, 3'b000, 2'd3, 0, 0, 0, 1, 32'hDEADBEEF));
    tbl.push_back(mk(3'b000, 3'b000, 2'd3, 0, 0, 0, 0, 0));
    tbl.push_back(mk(3'b011, 3'b000, 2'd1, 1, 1, 32'h80, 0, 0));
    tbl.push_back(mk(3'b011, 3'b000, 2'd1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(3'b011, 3'b000, 2'd1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(3'b011, 3'b010, 2'd1, 1, 0, 0, 1, 32'hCAFEF00D));
    tbl.push_back(mk(3'b001, 3'b000, 2'd3, 0, 0, 0, 0, 0));
    tbl.push_back(mk(3'b001, 3'b000, 2'd0, 1, 1, 32'h40, 0, 0));
    tbl.push_back(mk(3'b001, 3'b000, 2'd0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(3'b001, 3'b000, 2'd0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(3'b001, 3'b001, 2'd0, 1, 0, 0, 1, 32'hDEADBEEF));
    tbl.push_back(mk(3'b000, 3'b000, 2'd3, 0, 0, 0, 0, 0));
    setPort(0, 32'h40, 0);
    setPort(1, 32'h80, 0);
    setPort(2, 32'hC0, 0);
    foreach (tbl[i]) begin
      applyStimulus(tbl[i].req, tbl[i].we);
      @(negedge clk);
      checkOutput($sformatf("tbl[%0d].done", i), done, tbl[i].done);
      checkOutput($sformatf("tbl[%0d].gnt", i), gnt_id, tbl[i].gnt);
      checkOutput($sformatf("tbl[%0d].busy", i), busy, tbl[i].busy);
      checkOutput($sformatf("tbl[%0d].mem_en", i), mem_en, tbl[i].en);
      checkOutput($sformatf("tbl[%0d].mem_we", i), mem_we, tbl[i].mwe);
      if (tbl[i].en) checkOutput($sformatf("tbl[%0d].mem_addr", i), mem_addr, tbl[i].maddr);
      if (tbl[i].chk_rd) checkOutput($sformatf("tbl[%0d].rdata", i), rdata, tbl[i].rd);
    end
  endtask

  task automatic writeReadback();
    int k;
    setPort(1, 32'h100, 32'h12345678);
    applyStimulus(3'b010, 3'b010);
    @(negedge clk);
    checkOutput("wr_mem_en", mem_en, 1);
    checkOutput("wr_mem_we", mem_we, 1);
    checkOutput("wr_mem_addr", mem_addr, 32'h100);
    checkOutput("wr_mem_wdata", mem_wdata, 32'h12345678);
    checkOutput("wr_gnt", gnt_id, 1);
    @(negedge clk);
    checkOutput("wr_mem_we_drop", mem_we, 0);
    waitDone(1, 10, "wr_done", k);
    applyStimulus(3'b000, 3'b000);
    @(negedge clk);
    setPort(0, 32'h100, 0);
    applyStimulus(3'b001, 3'b000);
    waitDone(0, 10, "rd_back_done", k);
    checkOutput("rd_back_latency", k, LAT + 2);
    checkOutput("rd_back_rdata", rdata, 32'h12345678);
    applyStimulus(3'b000, 3'b000);
    @(negedge clk);
  endtask

  task automatic resetTest();
    bit saw;
    doReset();
    setPort(0, 32'h44, 0);
    applyStimulus(3'b001, 3'b000);
    @(negedge clk);
    @(negedge clk);
    checkOutput("rstmid_pre_busy", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(3'b000, 3'b000);
    checkOutput("rstmid_gnt", gnt_id, 3);
    checkOutput("rstmid_busy", busy, 0);
    checkOutput("rstmid_mem_en", mem_en, 0);
    checkOutput("rstmid_done", done, 0);
    saw = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done != 3'b000) saw = 1'b1;
    end
    checkOutput("rstmid_no_done", saw, 0);
  endtask

  task automatic maskTest();
    int k;
    doReset();
    setPort(0, 32'h48, 0);
    applyStimulus(3'b001, 3'b000);
    waitDone(0, 10, "mask_first_done", k);
    @(negedge clk);
    checkOutput("mask_after_done_gnt", gnt_id, 3);
    @(negedge clk);
    checkOutput("mask_no_regrant_en", mem_en, 0);
    checkOutput("mask_no_regrant_gnt", gnt_id, 3);
    @(negedge clk);
    checkOutput("mask_regrant_en", mem_en, 1);
    checkOutput("mask_regrant_gnt", gnt_id, 0);
    applyStimulus(3'b000, 3'b000);
    waitDone(0, 10, "mask_second_done", k);
    @(negedge clk);
  endtask

  task automatic grantOrderTest();
    int got[5];
    int exp_ord[5];
    int n, cyc;
    bit saw0;
`ifdef MEM_ARB_RR_EN
    exp_ord = '{0, 1, 2, 0, 1};
`else
    exp_ord = '{2, 1, 2, 1, 2};
`endif
    got = '{7, 7, 7, 7, 7};
    n = 0; cyc = 0; saw0 = 1'b0;
    doReset();
    for (int i = 0; i < 3; i++) setPort(i, 32'h200 + 32'(i) * 4, 0);
    applyStimulus(3'b111, 3'b000);
    while (n < 5 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (mem_en) begin
        got[n] = int'(gnt_id);
        n++;
      end
      if (done[0]) saw0 = 1'b1;
    end
    for (int i = 0; i < 5; i++) checkOutput($sformatf("grant_order[%0d]", i), got[i], exp_ord[i]);
`ifndef MEM_ARB_RR_EN
    checkOutput("ifetch_starved_done0", saw0, 0);
`endif
    applyStimulus(3'b000, 3'b000);
    repeat (LAT + 4) @(negedge clk);
  endtask

  function automatic int pickWinner(input logic [2:0] elig, input int rr);
`ifdef MEM_ARB_RR_EN
    for (int i = 0; i < 3; i++) if (elig[(rr + i) % 3]) return (rr + i) % 3;
    return 0;
`else
    if (rr < 0) return 0;
    if (elig[2]) return 2;
    if (elig[1]) return 1;
    return 0;
`endif
  endfunction

  task automatic startReq(input int r);
    req[r] = 1'b1;
    we[r]  = 1'($urandom_range(1));
    setPort(r, {22'd0, 8'($urandom_range(255, 128)), 2'b00}, $urandom);
  endtask

  task automatic randomTest(input int ncyc);
    int m_owner, m_age, m_rr, w, idx;
    logic [2:0] m_mask, elig, exp_done;
    logic m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rd;
    bit active[3];
    for (int i = 0; i < 256; i++) ref_mem[i] = initWord(i);
    doReset();
    m_owner = 3; m_age = 0; m_rr = 0; m_mask = 3'b000;
    m_we = 1'b0; m_addr = '0; m_wdata = '0; m_rd = '0;
    active = '{0, 0, 0};
    for (int c = 0; c < ncyc; c++) begin
      exp_done = (m_owner != 3 && m_age == LAT + 2) ? (3'b001 << m_owner) : 3'b000;
      for (int r = 0; r < 3; r++) begin
        if (exp_done[r]) begin
          active[r] = 0;
          if ($urandom_range(1) == 0) begin startReq(r); active[r] = 1; end
          else req[r] = 1'b0;
        end else if (!active[r]) begin
          if ($urandom_range(3) == 0) begin startReq(r); active[r] = 1; end
        end else if (m_owner == r && $urandom_range(7) == 0) begin
          we[r] = ~we[r];
          setPort(r, $urandom, $urandom);
          if ($urandom_range(1) == 0) req[r] = 1'b0;
        end
      end
      // Reference model advances one clock on the inputs just driven.
      if (m_owner == 3) begin
        elig = req & ~m_mask;
        m_mask = 3'b000;
        if (elig != 3'b000) begin
          w = pickWinner(elig, m_rr);
          m_owner = w; m_age = 1; m_we = we[w];
          m_addr = addr[w*AW +: AW];
          m_wdata = wdata[w*DW +: DW];
          idx = int'(m_addr[9:2]);
          if (m_we) ref_mem[idx] = m_wdata;
          else m_rd = ref_mem[idx];
        end
      end else if (m_age == LAT + 2) begin
        m_mask = 3'b001 << m_owner;
        m_rr = (m_owner + 1) % 3;
        m_owner = 3; m_age = 0;
      end else begin
        m_age++;
      end
      @(negedge clk);
      exp_done = (m_owner != 3 && m_age == LAT + 2) ? (3'b001 << m_owner) : 3'b000;
      checkOutput("rnd_done", done, exp_done);
      checkOutput("rnd_gnt", gnt_id, m_owner);
      checkOutput("rnd_busy", busy, m_owner != 3);
      checkOutput("rnd_mem_en", mem_en, m_owner != 3 && m_age == 1);
      checkOutput("rnd_mem_we", mem_we, m_owner != 3 && m_age == 1 && m_we);
      if (m_owner != 3 && m_age == 1) begin
        checkOutput("rnd_mem_addr", mem_addr, m_addr);
        if (m_we) checkOutput("rnd_mem_wdata", mem_wdata, m_wdata);
      end
      if (exp_done != 3'b000 && !m_we) checkOutput("rnd_rdata", rdata, m_rd);
    end
    applyStimulus(3'b000, 3'b000);
    repeat (LAT + 4) @(negedge clk);
  endtask

  initial begin
    addr  = '0;
    wdata = '0;
    $display("[TB] starting mem_port_arbiter bench, LAT=%0d", LAT);
    doReset();
    runTable();
    writeReadback();
    resetTest();
    maskTest();
    grantOrderTest();
    randomTest(2000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
